// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Multi-cycle sequencer for MIPS32 MULT/MULTU. One shared 32-bit ripple
//   adder builds the 64-bit product into HI/LO over 32 shift-add steps. Signed
//   operands are multiplied as magnitudes and the result is negated at the end
//   when the operand signs differ. The pipeline stalls while busy is high.
//
// Handshake: start is taken only in IDLE or DONE, on the rising edge where it
//   is high. a, b and is_signed are sampled on that edge. A start seen while
//   busy is dropped and never queued. done is high for exactly one cycle. hi
//   and lo then hold the product until the next done.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous, active-high reset
//   start      in   1     operation request
//   is_signed  in   1     1 = MULT (two's complement), 0 = MULTU
//   a          in   32    multiplicand
//   b          in   32    multiplier
//   busy       out  1     high in any state other than IDLE/DONE
//   done       out  1     one-cycle completion pulse
//   hi         out  32    product[63:32]
//   lo         out  32    product[31:0]
//   dbg_state  out  3     current FSM state, for observation only
// ---------------------------------------------------------------------------

// Plain 32-bit ripple-carry adder: {cout,s} = a + b + cin.
module bit32_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_s,
    output logic        o_cout
);
    logic w_c;

    always_comb begin
        o_s = '0;
        w_c = i_cin;
        for (int k = 0; k < 32; k++) begin
            o_s[k] = i_a[k] ^ i_b[k] ^ w_c;
            w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
        end
        o_cout = w_c;
    end
endmodule

module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        FIX_LO = 3'd4,
        FIX_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_mq, w_mq_nxt;      // multiplier, shifted out as LO fills in
    logic [WIDTH-1:0] r_acc, w_acc_nxt;    // running upper half of the product
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_neg, w_neg_nxt;    // product must be negated at the end
    logic             r_sgn, w_sgn_nxt;    // operation is MULT
    logic             r_c, w_c_nxt;        // carry from the LO negation into HI
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             w_load_out;

    logic [WIDTH-1:0] w_add_a, w_add_b, w_add_s;
    logic             w_add_cin, w_add_cout;
    logic [WIDTH:0]   w_sum;

    bit32_adder u_add (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_s    (w_add_s),
        .o_cout (w_add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_mq    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_sgn   <= 1'b0;
            r_c     <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcand <= w_mcand_nxt;
            r_mq    <= w_mq_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_neg   <= w_neg_nxt;
            r_sgn   <= w_sgn_nxt;
            r_c     <= w_c_nxt;
            if (w_load_out) begin
                r_hi <= w_acc_nxt;
                r_lo <= w_mq_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mcand_nxt = r_mcand;
        w_mq_nxt    = r_mq;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_neg_nxt   = r_neg;
        w_sgn_nxt   = r_sgn;
        w_c_nxt     = r_c;
        w_load_out  = 1'b0;
        w_add_a     = '0;
        w_add_b     = '0;
        w_add_cin   = 1'b0;
        w_sum       = {1'b0, r_acc};

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_mcand_nxt = a;
                    w_mq_nxt    = b;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_c_nxt     = 1'b0;
                    w_sgn_nxt   = is_signed;
                    w_neg_nxt   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (is_signed && a[WIDTH-1])      w_state_nxt = NEG_A;
                    else if (is_signed && b[WIDTH-1]) w_state_nxt = NEG_B;
                    else                              w_state_nxt = ITER;
                end else if (r_state == DONE) begin
                    w_state_nxt = IDLE;
                end
            end
            NEG_A: begin
                // The most negative value negates to itself; read as unsigned
                // it is already the correct magnitude.
                w_add_a     = ~r_mcand;
                w_add_cin   = 1'b1;
                w_mcand_nxt = w_add_s;
                w_state_nxt = (r_sgn && r_mq[WIDTH-1]) ? NEG_B : ITER;
            end
            NEG_B: begin
                w_add_a     = ~r_mq;
                w_add_cin   = 1'b1;
                w_mq_nxt    = w_add_s;
                w_state_nxt = ITER;
            end
            ITER: begin
                w_add_a   = r_acc;
                w_add_b   = r_mcand;
                w_sum     = r_mq[0] ? {w_add_cout, w_add_s} : {1'b0, r_acc};
                // 65-bit {sum, mq} shifted right by one; the adder carry lands
                // in the top bit of acc.
                w_acc_nxt = w_sum[WIDTH:1];
                w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    if (r_neg) begin
                        w_state_nxt = FIX_LO;
                    end else begin
                        w_state_nxt = DONE;
                        w_load_out  = 1'b1;
                    end
                end
            end
            FIX_LO: begin
                w_add_a     = ~r_mq;
                w_add_cin   = 1'b1;
                w_mq_nxt    = w_add_s;
                w_c_nxt     = w_add_cout;
                w_state_nxt = FIX_HI;
            end
            FIX_HI: begin
                // A zero LO carries out, so negating zero yields zero overall.
                w_add_a     = ~r_acc;
                w_add_cin   = r_c;
                w_acc_nxt   = w_add_s;
                w_state_nxt = DONE;
                w_load_out  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;
endmodule
